countdown_timer: RTL and testbench
==================================

// Module: countdown_timer
// PURPOSE
//  Down-counting MM:SS.cc timer for the DE1-SoC board; companion to the stopwatch (counts toward zero, not up).
//  User presets minutes/seconds with keys, starts/pauses, gets an alarm LED at 00:00.00.
//  Drives six active-low 7-seg digits (hex5..hex0 = M M S S c c) via the existing sevenseg decoder.
// PARAMETERS
//  TICK_DIV      500000  clk cycles per 10 ms tick (50 MHz clk)
//  DEBOUNCE_CYC  255     consecutive stable samples before a key change is accepted
// PORTS
//  clk              in   1  system clock, 50 MHz
//  key_reset        in   1  asynchronous, active-low reset (board key)
//  key_start_pause  in   1  active-low key: start / pause / resume / acknowledge alarm
//  key_set_min      in   1  active-low key: +1 minute while IDLE
//  key_set_sec      in   1  active-low key: +1 second while IDLE; cancel while PAUSED
//  hex0..hex5       out  7  each; active-low segments gfe_dcba; hex5 = minute tens
//  led_running      out  1  1 while RUNNING
//  led_alarm        out  1  1 while ALARM
// BEHAVIOUR
//  Reset (key_reset=0, async): state=IDLE, all six digits and preset=0, prescaler=0, debouncers
//   idle-released; hex* = 7'b100_0000 ("0"); both LEDs 0. Release is synchronised (2 flops) before use.
//  Key event: one-cycle pulse on the debounced 1->0 (press) transition only; release produces nothing.
//   Input held stable DEBOUNCE_CYC cycles before acceptance; glitches shorter than that are ignored.
//  FSM states: IDLE, RUNNING, PAUSED, ALARM.
//   IDLE   : set_min -> minutes+1 (BCD, 99 wraps to 00, seconds unchanged);
//            set_sec -> seconds+1 (BCD, 59 wraps to 00, no carry into minutes); centiseconds stay 00.
//            start -> if time != 00:00.00: preset<=time, prescaler<=0, go RUNNING; else ignored.
//   RUNNING: prescaler counts 0..TICK_DIV-1; at TICK_DIV-1 emit tick, wrap to 0.
//            tick: BCD decrement with borrow: cs_lo 0->9, cs_hi 0->9, s_lo 0->9, s_hi 0->5,
//            m_lo 0->9, m_hi (never borrows, as 00:00.00 is never decremented).
//            Tick that produces 00:00.00 -> ALARM on the next cycle. start -> PAUSED.
//   PAUSED : digits and prescaler frozen (fraction of tick kept); start -> RUNNING;
//            set_sec -> IDLE with time<=preset; set_min ignored.
//   ALARM  : digits stay 00:00.00; start -> IDLE with time<=preset (re-armed, same value).
//  Simultaneous events same cycle: start has priority; other key pulses that cycle are dropped.
//   set_min and set_sec together in IDLE: both applied.
//  Tick and start on same cycle in RUNNING: tick decrement applied, then state -> PAUSED.
//  Display: hex digits track live counter every cycle (one-cycle register latency, no freeze).
//  Latency: key press to state change = DEBOUNCE_CYC + 3 cycles (sync + debounce + edge).
//  Out-of-range BCD never reachable; decoder default (all off) must never appear.
//  key_reset asserted mid-run: immediate return to reset state; preset lost.
// STRUCTURE
//  Shared include timer_defs.vh: FSM state encodings, BCD limits (9, 5), segment constant for "0".
//  Sub-module key_debounce (sync + stable counter + press pulse), instantiated three times,
//   parameter DEBOUNCE_CYC. Six sevenseg instances for display. Single always block per concern:
//   FSM, prescaler, digit chain; all registers on posedge clk / negedge key_reset.
// TESTING (bench overrides TICK_DIV=4, DEBOUNCE_CYC=3)
//  1 Reset mid-RUNNING at 01:23.45 -> all hex=7'b100_0000, leds 0, state IDLE, same cycle async.
//  2 IDLE, set_sec x61 -> 00:01.00 (59 wraps 00); set_min x100 -> 00:01.00 (99 wraps 00).
//  3 Preset 01:00, start -> after 1 tick 00:59.99; after 6000 ticks 00:00.00, led_alarm=1 next cycle.
//  4 RUNNING, start at prescaler=2 -> PAUSED, digits frozen 20 cycles; resume -> next tick after 2 clk.
//  5 PAUSED at 00:30.10, set_sec -> IDLE, display 01:00.00 (preset); ALARM + start -> IDLE 01:00.00.
//  6 Start at 00:00.00 -> stays IDLE; 2-cycle glitch on key_start_pause -> no event; start+set_min
//    same cycle in IDLE at 00:05 -> RUNNING, minutes unchanged.

Source files
------------

// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the MM:SS.cc countdown timer: state encodings, BCD limits,
// digit record type and the BCD/segment helper functions.
package countdown_timer_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUNNING = 2'd1;
    localparam logic [1:0] ST_PAUSED  = 2'd2;
    localparam logic [1:0] ST_ALARM   = 2'd3;

    localparam logic [3:0] BCD_MAX_9 = 4'd9;
    localparam logic [3:0] BCD_MAX_5 = 4'd5;

    localparam logic [6:0] SEG_ZERO = 7'b100_0000;

    typedef struct packed {
        logic [3:0] m_hi;
        logic [3:0] m_lo;
        logic [3:0] s_hi;
        logic [3:0] s_lo;
        logic [3:0] c_hi;
        logic [3:0] c_lo;
    } bcd_time_t;

    // Active-low gfe_dcba; anything outside 0..9 blanks the digit.
    function automatic logic [6:0] sevenseg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_ZERO;
            4'd1:    s = 7'b111_1001;
            4'd2:    s = 7'b010_0100;
            4'd3:    s = 7'b011_0000;
            4'd4:    s = 7'b001_1001;
            4'd5:    s = 7'b001_0010;
            4'd6:    s = 7'b000_0010;
            4'd7:    s = 7'b111_1000;
            4'd8:    s = 7'b000_0000;
            4'd9:    s = 7'b001_0000;
            default: s = 7'b111_1111;
        endcase
        return s;
    endfunction

    function automatic bcd_time_t inc_min(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.m_lo == BCD_MAX_9) begin
            r.m_lo = '0;
            r.m_hi = (t.m_hi == BCD_MAX_9) ? 4'd0 : t.m_hi + 4'd1;
        end else begin
            r.m_lo = t.m_lo + 4'd1;
        end
        return r;
    endfunction

    function automatic bcd_time_t inc_sec(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.s_lo == BCD_MAX_9) begin
            r.s_lo = '0;
            r.s_hi = (t.s_hi == BCD_MAX_5) ? 4'd0 : t.s_hi + 4'd1;
        end else begin
            r.s_lo = t.s_lo + 4'd1;
        end
        return r;
    endfunction

    // m_hi is never borrowed from: 00:00.00 is never decremented.
    function automatic bcd_time_t time_dec(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.c_lo != '0) begin
            r.c_lo = t.c_lo - 4'd1;
        end else begin
            r.c_lo = BCD_MAX_9;
            if (t.c_hi != '0) begin
                r.c_hi = t.c_hi - 4'd1;
            end else begin
                r.c_hi = BCD_MAX_9;
                if (t.s_lo != '0) begin
                    r.s_lo = t.s_lo - 4'd1;
                end else begin
                    r.s_lo = BCD_MAX_9;
                    if (t.s_hi != '0) begin
                        r.s_hi = t.s_hi - 4'd1;
                    end else begin
                        r.s_hi = BCD_MAX_5;
                        if (t.m_lo != '0) begin
                            r.m_lo = t.m_lo - 4'd1;
                        end else begin
                            r.m_lo = BCD_MAX_9;
                            r.m_hi = t.m_hi - 4'd1;
                        end
                    end
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Active-low key conditioner: 2-flop synchroniser, stable-sample counter and a
// one-cycle pulse on an accepted press (release produces nothing).
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int unsigned CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    logic [1:0]    sync;
    logic          stable;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync   <= '1;
            stable <= 1'b1;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync  <= {sync[0], key_n};
            press <= 1'b0;
            if (sync[1] != stable) begin
                if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
                    stable <= sync[1];
                    cnt    <= '0;
                    press  <= ~sync[1];
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// MM:SS.cc countdown timer: key presets, start/pause/cancel, alarm at 00:00.00,
// six registered active-low seven-segment digit outputs.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int unsigned TICK_DIV     = 500000,
    parameter int unsigned DEBOUNCE_CYC = 255
) (
    input  logic       clk,
    input  logic       key_reset,
    input  logic       key_start_pause,
    input  logic       key_set_min,
    input  logic       key_set_sec,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3,
    output logic [6:0] hex4,
    output logic [6:0] hex5,
    output logic       led_running,
    output logic       led_alarm
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [1:0]    rst_sync;
    logic          rst_n;
    logic          ev_start, ev_min, ev_sec;
    logic [1:0]    state;
    logic [PW-1:0] presc;
    logic          tick;
    logic          is_zero;
    bcd_time_t     cur, preset, idle_next;

    // Assertion is immediate; release is retimed so all flops leave reset together.
    always_ff @(posedge clk or negedge key_reset) begin
        if (!key_reset) rst_sync <= '0;
        else            rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_start (
        .clk(clk), .rst_n(rst_n), .key_n(key_start_pause), .press(ev_start));
    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_min (
        .clk(clk), .rst_n(rst_n), .key_n(key_set_min), .press(ev_min));
    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_sec (
        .clk(clk), .rst_n(rst_n), .key_n(key_set_sec), .press(ev_sec));

    assign is_zero = (cur == '0);
    assign tick    = (state == ST_RUNNING) && (presc == PW'(TICK_DIV - 1));

    always_comb begin
        idle_next = cur;
        if (ev_min) idle_next = inc_min(idle_next);
        if (ev_sec) idle_next = inc_sec(idle_next);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    if (ev_start && !is_zero) state <= ST_RUNNING;
                ST_RUNNING: begin
                    if (is_zero)       state <= ST_ALARM;
                    else if (ev_start) state <= ST_PAUSED;
                end
                ST_PAUSED: begin
                    if (ev_start)    state <= ST_RUNNING;
                    else if (ev_sec) state <= ST_IDLE;
                end
                ST_ALARM:   if (ev_start) state <= ST_IDLE;
                default:    state <= ST_IDLE;
            endcase
        end
    end

    // A pausing start holds the count so the partial tick survives the pause.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (state == ST_IDLE && ev_start && !is_zero) begin
            presc <= '0;
        end else if (state == ST_RUNNING) begin
            if (tick)           presc <= '0;
            else if (!ev_start) presc <= presc + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur    <= '0;
            preset <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ev_start) begin
                        if (!is_zero) preset <= cur;
                    end else begin
                        cur <= idle_next;
                    end
                end
                ST_RUNNING: if (tick && !is_zero) cur <= time_dec(cur);
                ST_PAUSED:  if (!ev_start && ev_sec) cur <= preset;
                ST_ALARM:   if (ev_start) cur <= preset;
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {hex5, hex4, hex3, hex2, hex1, hex0} <= {6{SEG_ZERO}};
        end else begin
            hex5 <= sevenseg(cur.m_hi);
            hex4 <= sevenseg(cur.m_lo);
            hex3 <= sevenseg(cur.s_hi);
            hex2 <= sevenseg(cur.s_lo);
            hex1 <= sevenseg(cur.c_hi);
            hex0 <= sevenseg(cur.c_lo);
        end
    end

    assign led_running = (state == ST_RUNNING);
    assign led_alarm   = (state == ST_ALARM);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with TICK_DIV=4, DEBOUNCE_CYC=3: a vector
// table for presetting in IDLE plus hand-timed run/pause/alarm/reset sequences.
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       key_reset = 1'b0;
    logic       key_start_pause = 1'b1;
    logic       key_set_min = 1'b1;
    logic       key_set_sec = 1'b1;
    logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
    logic       led_running, led_alarm;

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    typedef struct {
        int unsigned mask;   // 0 = wait reps cycles; bit0 start, bit1 min, bit2 sec
        int unsigned reps;
        logic [23:0] exp;    // expected MMSScc as BCD nibbles
        logic        run;
        logic        alarm;
    } vec_t;

    vec_t vecs [9];

    countdown_timer #(.TICK_DIV(4), .DEBOUNCE_CYC(3)) dut (
        .clk(clk), .key_reset(key_reset), .key_start_pause(key_start_pause),
        .key_set_min(key_set_min), .key_set_sec(key_set_sec),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5),
        .led_running(led_running), .led_alarm(led_alarm));

    always #5 clk = ~clk;

    function automatic logic [41:0] disp_of(input logic [23:0] bcd);
        logic [41:0] r;
        for (int i = 0; i < 6; i++) r[i*7 +: 7] = seg_tbl[bcd[i*4 +: 4]];
        return r;
    endfunction

    task automatic chk_disp(input string name, input logic [23:0] exp_bcd);
        logic [41:0] got, exp;
        got = {hex5, hex4, hex3, hex2, hex1, hex0};
        exp = disp_of(exp_bcd);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: hex got %h required %h (time %h)", name, got, exp, exp_bcd);
        end
    endtask

    task automatic chk_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b required %b", name, got, exp);
        end
    endtask

    task automatic key_down(input int unsigned mask);
        if (mask[0]) key_start_pause = 1'b0;
        if (mask[1]) key_set_min = 1'b0;
        if (mask[2]) key_set_sec = 1'b0;
    endtask

    task automatic key_up();
        key_start_pause = 1'b1;
        key_set_min = 1'b1;
        key_set_sec = 1'b1;
    endtask

    task automatic press(input int unsigned mask);
        @(negedge clk);
        key_down(mask);
        repeat (8) @(negedge clk);
        key_up();
        repeat (8) @(negedge clk);
    endtask

    // Returns on the first falling edge where the chosen LED shows val.
    task automatic wait_led(input string name, input bit alarm_sel, input logic val);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if ((alarm_sel ? led_alarm : led_running) === val) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s: led timeout, got %b required %b", name,
                     alarm_sel ? led_alarm : led_running, val);
        end
    endtask

    initial begin
        vecs[0] = '{0, 4,  24'h000000, 1'b0, 1'b0};
        vecs[1] = '{1, 1,  24'h000000, 1'b0, 1'b0};
        vecs[2] = '{4, 59, 24'h005900, 1'b0, 1'b0};
        vecs[3] = '{4, 1,  24'h000000, 1'b0, 1'b0};
        vecs[4] = '{4, 1,  24'h000100, 1'b0, 1'b0};
        vecs[5] = '{2, 99, 24'h990100, 1'b0, 1'b0};
        vecs[6] = '{2, 1,  24'h000100, 1'b0, 1'b0};
        vecs[7] = '{6, 1,  24'h010200, 1'b0, 1'b0};
        vecs[8] = '{4, 58, 24'h010000, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        chk_disp("reset display", 24'h000000);
        chk_bit("reset led_running", led_running, 1'b0);
        key_reset = 1'b1;

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].mask == 0) repeat (vecs[i].reps) @(negedge clk);
            else for (int r = 0; r < int'(vecs[i].reps); r++) press(vecs[i].mask);
            chk_disp($sformatf("vec%0d display", i), vecs[i].exp);
            chk_bit($sformatf("vec%0d led_running", i), led_running, vecs[i].run);
            chk_bit($sformatf("vec%0d led_alarm", i), led_alarm, vecs[i].alarm);
        end

        // Full run from 01:00.00: tick k lands on edge 4k after the run edge.
        key_down(1);
        wait_led("run start", 1'b0, 1'b1);
        key_up();
        repeat (4) @(negedge clk);
        chk_disp("before first tick", 24'h010000);
        @(negedge clk);
        chk_disp("first tick", 24'h005999);
        chk_bit("running led", led_running, 1'b1);
        repeat (24000 - 5) @(negedge clk);
        chk_disp("last tick pending", 24'h000001);
        chk_bit("alarm not yet", led_alarm, 1'b0);
        @(negedge clk);
        chk_disp("reached zero", 24'h000000);
        chk_bit("alarm led", led_alarm, 1'b1);
        chk_bit("running off at alarm", led_running, 1'b0);
        repeat (10) @(negedge clk);
        chk_disp("alarm holds zero", 24'h000000);
        press(1);
        chk_disp("alarm ack restores preset", 24'h010000);
        chk_bit("alarm ack led_alarm", led_alarm, 1'b0);

        // Pause after exactly 2990 ticks, then cancel back to the preset.
        key_down(1);
        wait_led("run2 start", 1'b0, 1'b1);
        key_up();
        repeat (11956) @(negedge clk);
        key_down(1);
        wait_led("run2 pause", 1'b0, 1'b0);
        chk_disp("paused at 00:30.10", 24'h003010);
        key_up();
        repeat (8) @(negedge clk);
        press(4);
        chk_disp("cancel restores preset", 24'h010000);
        chk_bit("cancel led_running", led_running, 1'b0);
        chk_bit("cancel led_alarm", led_alarm, 1'b0);

        // Pause with the prescaler at 2, then the first tick after resume lands 2 clocks later.
        key_down(1);
        wait_led("run3 start", 1'b0, 1'b1);
        key_up();
        repeat (9) @(negedge clk);
        key_down(1);
        wait_led("run3 pause", 1'b0, 1'b0);
        chk_disp("paused after 3 ticks", 24'h005997);
        key_up();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk_disp($sformatf("frozen cycle %0d", i), 24'h005997);
        end
        key_down(1);
        wait_led("resume", 1'b0, 1'b1);
        key_up();
        @(negedge clk);
        chk_disp("resume +1", 24'h005997);
        @(negedge clk);
        chk_disp("resume +2", 24'h005997);
        @(negedge clk);
        chk_disp("resume tick", 24'h005996);

        // Asynchronous reset mid-run.
        #1 key_reset = 1'b0;
        #1;
        chk_disp("async reset display", 24'h000000);
        chk_bit("async reset led_running", led_running, 1'b0);
        chk_bit("async reset led_alarm", led_alarm, 1'b0);
        repeat (3) @(negedge clk);
        key_reset = 1'b1;
        repeat (5) @(negedge clk);
        press(1);
        chk_disp("preset lost, start ignored", 24'h000000);
        chk_bit("start at zero stays idle", led_running, 1'b0);

        for (int i = 0; i < 5; i++) press(4);
        chk_disp("preset 00:05", 24'h000500);
        @(negedge clk);
        key_down(1);
        repeat (2) @(negedge clk);
        key_up();
        repeat (20) @(negedge clk);
        chk_bit("glitch ignored", led_running, 1'b0);
        chk_disp("glitch display", 24'h000500);

        key_down(3);
        wait_led("start+min", 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        chk_disp("start wins over min", 24'h000500);
        chk_bit("start+min running", led_running, 1'b1);
        key_up();
        repeat (8) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
